// File: rtl/data_mem_unit.sv
// Single-cycle RV32I data memory: byte/half/word loads and stores with misalignment detection.
// Defining DMEM_ACCESS_CNT_EN adds load_cnt/store_cnt counters of legal completed accesses.
module data_mem_unit #(
  parameter  int DEPTH_WORDS = 256,
  localparam int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] addr,
  input  logic [31:0] wr_data,
  input  logic        mem_write,
  input  logic        mem_read,
  input  logic [2:0]  funct3,
  output logic [31:0] rd_data,
  output logic        misaligned,
  output logic        err_sticky
`ifdef DMEM_ACCESS_CNT_EN
  ,
  output logic [31:0] load_cnt,
  output logic [31:0] store_cnt
`endif
);

  logic [31:0]      mem [DEPTH_WORDS];
  logic [IDX_W-1:0] word_idx;
  logic [1:0]       lane;
  logic [31:0]      cur_word;
  logic [7:0]       cur_byte;
  logic [15:0]      cur_half;
  logic             is_half;
  logic             is_word;
  logic             ld_illegal;
  logic             st_illegal;
  logic             bad_align;
  logic             conflict;
  logic             store_ok;
  logic             load_ok;
  logic [3:0]       byte_en;
  logic [31:0]      store_word;
  logic             unused_addr;

  // Upper address bits are deliberately ignored so the array wraps.
  assign unused_addr = ^addr[31:IDX_W+2];

  assign word_idx = addr[IDX_W+1:2];
  assign lane     = addr[1:0];
  assign cur_word = mem[word_idx];
  assign cur_byte = cur_word[{lane, 3'b000} +: 8];
  assign cur_half = addr[1] ? cur_word[31:16] : cur_word[15:0];

  assign is_half    = (funct3[1:0] == 2'b01);
  assign is_word    = (funct3 == 3'b010);
  assign ld_illegal = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
  assign st_illegal = funct3[2] || (funct3[1:0] == 2'b11);
  assign bad_align  = (is_half && addr[0]) || (is_word && (addr[1:0] != 2'b00));
  assign conflict   = mem_read && mem_write;

  assign misaligned = (mem_read || mem_write) &&
                      (bad_align || (mem_read && ld_illegal) ||
                       (mem_write && st_illegal) || conflict);

  // A read+write conflict still commits the store when the store itself is legal.
  assign store_ok = mem_write && !st_illegal && !bad_align;
  assign load_ok  = mem_read && !mem_write && !ld_illegal && !bad_align;

  always_comb begin
    byte_en    = 4'b0000;
    store_word = 32'h0;
    case (funct3[1:0])
      2'b00: begin
        byte_en    = 4'b0001 << lane;
        store_word = {4{wr_data[7:0]}};
      end
      2'b01: begin
        byte_en    = addr[1] ? 4'b1100 : 4'b0011;
        store_word = {2{wr_data[15:0]}};
      end
      default: begin
        byte_en    = 4'b1111;
        store_word = wr_data;
      end
    endcase
  end

  always_comb begin
    rd_data = 32'h0;
    if (rst_n && load_ok) begin
      case (funct3)
        3'b000:  rd_data = {{24{cur_byte[7]}}, cur_byte};
        3'b100:  rd_data = {24'h0, cur_byte};
        3'b001:  rd_data = {{16{cur_half[15]}}, cur_half};
        3'b101:  rd_data = {16'h0, cur_half};
        3'b010:  rd_data = cur_word;
        default: rd_data = 32'h0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH_WORDS; i++) mem[i] <= 32'h0;
    end else if (store_ok) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) mem[word_idx][8*b +: 8] <= store_word[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_sticky <= 1'b0;
    else if (misaligned) err_sticky <= 1'b1;
  end

`ifdef DMEM_ACCESS_CNT_EN
  // Conflicting read+write cycles are excluded from both counts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_cnt  <= 32'h0;
      store_cnt <= 32'h0;
    end else begin
      if (load_ok) load_cnt <= load_cnt + 32'd1;
      if (store_ok && !conflict) store_cnt <= store_cnt + 32'd1;
    end
  end
`endif

endmodule
